// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer sitting beside the EX ALU.
// Latency: accept at cycle t -> done_o at t+33 (t+1 for divide-by-zero / signed overflow).
// Backpressure: stall_o holds EX while busy; rdy_in=0 freezes everything; flush_in aborts.
// Ports: clk_in/rst_in (sync active-high), rdy_in, flush_in, start_in/op_in/op1_in/op2_in/
//        rd_addr_in (request), stall_o, done_o/result_o/rd_addr_o (one-cycle result).
module ex_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            flush_in,
   input  logic            start_in,
   input  logic [2:0]      op_in,
   input  logic [XLEN-1:0] op1_in,
   input  logic [XLEN-1:0] op2_in,
   input  logic [4:0]      rd_addr_in,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(XLEN-1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;       // op[1:0]; MUL vs DIV is carried by the state
   logic                neg_q, neg_d;     // final result must be negated
   logic [2*XLEN-1:0]   acc_q, acc_d;     // MUL: partial product; DIV: {remainder, dividend/quotient}
   logic [2*XLEN-1:0]   mcand_q, mcand_d; // MUL: shifting multiplicand; DIV: divisor in low half
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic [4:0]          rd_q, rd_d;

   // Request decode
   logic            sgn1, sgn2, neg1, neg2, is_div, div_zero, div_ovf, special;
   logic [XLEN-1:0] mag1, mag2;

   always_comb begin
      sgn1     = (op_in != 3'd3) && (op_in != 3'd5) && (op_in != 3'd7);
      sgn2     = sgn1 && (op_in != 3'd2);
      neg1     = sgn1 & op1_in[XLEN-1];
      neg2     = sgn2 & op2_in[XLEN-1];
      mag1     = neg1 ? -op1_in : op1_in;
      mag2     = neg2 ? -op2_in : op2_in;
      is_div   = op_in[2];
      div_zero = is_div && (op2_in == '0);
      div_ovf  = is_div && !op_in[0] && (op1_in == MIN_NEG) && (op2_in == '1);
      special  = div_zero | div_ovf;
   end

   // Multiply step: add shifted multiplicand when the current multiplier bit is set
   logic [2*XLEN-1:0] prod_nx, mul_fin;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      prod_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
      mul_fin = neg_q ? -prod_nx : prod_nx;
      mul_res = (op_q == 2'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
   end

   // Restoring divide step: shift next dividend bit into the remainder, try a subtract
   logic [XLEN:0]   trial, diff;
   logic            ge;
   logic [XLEN-1:0] rem_nx, quo_nx, div_res;

   always_comb begin
      trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff    = trial - {1'b0, mcand_q[XLEN-1:0]};
      ge      = ~diff[XLEN];
      rem_nx  = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
      quo_nx  = {acc_q[XLEN-2:0], ge};
      if (op_q[1]) div_res = neg_q ? -rem_nx : rem_nx;
      else         div_res = neg_q ? -quo_nx : quo_nx;
   end

   // Next-state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      res_d    = res_q;
      rd_d     = rd_q;
      if (rdy_in) begin
         if (flush_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
            rd_d    = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_in) begin
                     op_d  = op_in[1:0];
                     rd_d  = rd_addr_in;
                     cnt_d = '0;
                     if (div_zero) begin
                        res_d   = op_in[1] ? op1_in : '1;
                        state_d = S_DONE;
                     end else if (div_ovf) begin
                        res_d   = op_in[1] ? '0 : MIN_NEG;
                        state_d = S_DONE;
                     end else if (is_div) begin
                        acc_d   = {{XLEN{1'b0}}, mag1};
                        mcand_d = {{XLEN{1'b0}}, mag2};
                        neg_d   = op_in[1] ? neg1 : (neg1 ^ neg2);
                        state_d = S_DIV;
                     end else begin
                        acc_d    = '0;
                        mcand_d  = {{XLEN{1'b0}}, mag1};
                        mplier_d = mag2;
                        neg_d    = neg1 ^ neg2;
                        state_d  = S_MUL;
                     end
                  end
               end
               S_MUL: begin
                  acc_d    = prod_nx;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  cnt_d    = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_END) begin
                     cnt_d   = '0;
                     res_d   = mul_res;
                     state_d = S_DONE;
                  end
               end
               S_DIV: begin
                  acc_d = {rem_nx, quo_nx};
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_END) begin
                     cnt_d   = '0;
                     res_d   = div_res;
                     state_d = S_DONE;
                  end
               end
               S_DONE:  state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         res_q    <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         res_q    <= res_d;
         rd_q     <= rd_d;
      end
   end

   // Stall is low in DONE so EX captures the result on the same edge it advances.
   always_comb begin
      stall_o   = (state_q == S_MUL) || (state_q == S_DIV) ||
                  ((state_q == S_IDLE) && start_in && !flush_in && !special);
      done_o    = (state_q == S_DONE);
      result_o  = done_o ? res_q : '0;
      rd_addr_o = done_o ? rd_q  : '0;
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        flush_in = 1'b0;
   logic        start_in = 1'b0;
   logic [2:0]  op_in = '0;
   logic [31:0] op1_in = '0;
   logic [31:0] op2_in = '0;
   logic [4:0]  rd_addr_in = '0;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;

   ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .start_in(start_in), .op_in(op_in), .op1_in(op1_in), .op2_in(op2_in),
      .rd_addr_in(rd_addr_in), .stall_o(stall_o), .done_o(done_o),
      .result_o(result_o), .rd_addr_o(rd_addr_o)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Independent reference for RV32M semantics
   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      longint      la, lb, lp;
      logic [63:0] up;
      sa = a; sb = b;
      la = sa; lb = sb;
      case (op)
         3'd0: begin lp = la * lb; return lp[31:0]; end
         3'd1: begin lp = la * lb; return lp[63:32]; end
         3'd2: begin lb = longint'({32'b0, b}); lp = la * lb; return lp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return sa / sb;
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Scoreboard consumer: every done_o pulse must match the oldest expectation
   always @(negedge clk_in) begin
      if (done_o) begin
         if (sb_q.size() == 0) begin
            chk("spurious_done", {31'b0, done_o}, 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", result_o, e.res);
            chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, e.rd});
            chk("latency", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Called at posedge+1; drives the request for one cycle and reports stall_o in that cycle
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                        input bit push, output logic st);
      exp_t e;
      start_in = 1'b1; op_in = op; op1_in = a; op2_in = b; rd_addr_in = rd;
      if (push) begin
         e.res = exp_res; e.rd = rd; e.cyc = cyc + lat;
         sb_q.push_back(e);
      end
      #3;
      st = stall_o;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 80 && sb_q.size() != 0; i++) tick();
      if (sb_q.size() != 0) begin
         chk("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      tick();
   endtask

   logic        st;
   logic [2:0]  rop;
   logic [31:0] ra, rb;

   initial begin
      tick(); tick();
      @(negedge clk_in);
      chk("rst_stall", {31'b0, stall_o}, 0);
      chk("rst_done", {31'b0, done_o}, 0);
      chk("rst_result", result_o, 0);
      chk("rst_rd", {27'b0, rd_addr_o}, 0);
      tick();
      rst_in = 1'b0;
      tick();

      // MUL with per-cycle stall profile
      issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 1, st);
      chk("mul_stall_t", {31'b0, st}, 1);
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk_in);
         chk("mul_stall_run", {31'b0, stall_o}, (k <= 32) ? 32'd1 : 32'd0);
      end
      tick();
      wait_drain();

      issue(3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33, 1, st); wait_drain();
      issue(3'd3, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 33, 1, st); wait_drain();
      issue(3'd2, 32'hFFFFFFFF, 32'd2,        5'd4, 32'hFFFFFFFF, 33, 1, st); wait_drain();
      issue(3'd4, 32'hFFFFFFEC, 32'd3,        5'd5, 32'hFFFFFFFA, 33, 1, st); wait_drain();
      issue(3'd6, 32'hFFFFFFEC, 32'd3,        5'd6, 32'hFFFFFFFE, 33, 1, st); wait_drain();
      issue(3'd5, 32'd20,       32'd3,        5'd7, 32'd6,        33, 1, st); wait_drain();
      issue(3'd7, 32'd20,       32'd3,        5'd8, 32'd2,        33, 1, st); wait_drain();

      // Special-case divides finish the cycle after accept without stalling
      issue(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1, 1, st);
      chk("divz_stall", {31'b0, st}, 0);
      wait_drain();
      issue(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1, 1, st); wait_drain();
      issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 1, st);
      chk("ovf_stall", {31'b0, st}, 0);
      wait_drain();
      issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, 1, 1, st); wait_drain();

      // Flush at t+10 of a DIV, restart at t+12
      issue(3'd4, 32'd1000, 32'd7, 5'd13, 32'h0, 0, 0, st);
      for (int i = 0; i < 9; i++) tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      @(negedge clk_in);
      chk("flush_stall", {31'b0, stall_o}, 0);
      chk("flush_done", {31'b0, done_o}, 0);
      tick();
      issue(3'd5, 32'd100, 32'd7, 5'd14, 32'd14, 33, 1, st);
      wait_drain();

      // Flush beats start in the same cycle
      start_in = 1'b1; flush_in = 1'b1; op_in = 3'd0; op1_in = 32'd3; op2_in = 32'd3;
      #3;
      chk("flush_vs_start_stall", {31'b0, stall_o}, 0);
      tick();
      start_in = 1'b0; flush_in = 1'b0;
      @(negedge clk_in);
      chk("flush_vs_start_idle", {31'b0, stall_o}, 0);
      tick();

      // rdy_in low for 5 cycles mid-MUL delays done by exactly 5
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFE, 38, 1, st);
      for (int i = 0; i < 9; i++) tick();
      rdy_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("frozen_stall", {31'b0, stall_o}, 1);
      rdy_in = 1'b1;
      wait_drain();

      // Reset mid-DIV clears everything and no result appears
      issue(3'd4, 32'd12345, 32'd17, 5'd16, 32'h0, 0, 0, st);
      for (int i = 0; i < 7; i++) tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("rst_mid_stall", {31'b0, stall_o}, 0);
      chk("rst_mid_done", {31'b0, done_o}, 0);
      chk("rst_mid_result", result_o, 0);
      chk("rst_mid_rd", {27'b0, rd_addr_o}, 0);
      for (int i = 0; i < 40; i++) tick();

      // Randomised operations against the reference model
      for (int n = 0; n < 16; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (n % 5 == 4) ? 32'h0 : $urandom;
         issue(rop, ra, rb, 5'(n + 17), ref_op(rop, ra, rb),
               (rop[2] && rb == 0) ? 1 : 33, 1, st);
         wait_drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
